bsg_chip_tag_packet_rx: RTL and testbench
=========================================

// Module: bsg_chip_tag_packet_rx
//
// PURPOSE
// - Serial bsg_tag packet receiver. It consumes the gated tag bitstream (tag_en & tag_data) that the chip
//   block fans out to all tag clients.
// - Parses start/node_id/data_not_reset/len/payload fields LSB-first and emits one parallel packet
//   per valid frame.
// - Runs in the tag_clk domain. It feeds per-node tag decode and clock-generator configuration logic.
//
// PARAMETERS
// - tag_lg_els_p         9   width of node_id field
// - max_payload_width_p  16  largest legal payload; width of payload_o
// - lg_payload_width_lp  $clog2(max_payload_width_p+1) (derived, 5 at default); width of len field
//
// PORTS
// - clk_i              in   1                    tag clock
// - reset_i            in   1                    synchronous, active-high reset
// - data_i             in   1                    serial tag bit, sampled every rising clk_i
// - v_o                out  1                    one-cycle pulse: packet fields valid
// - node_id_o          out  tag_lg_els_p         destination node of last packet
// - data_not_reset_o   out  1                    1=data packet, 0=client reset packet
// - len_o              out  lg_payload_width_lp  payload length of last packet
// - payload_o          out  max_payload_width_p  payload, bit k = k-th payload bit; bits >= len are 0
// - len_err_o          out  1                    one-cycle pulse: len > max_payload_width_p
// - pkt_count_o        out  8                    saturating count of v_o pulses
//
// BEHAVIOUR
// - FSM states: IDLE -> NODE -> DNR -> LEN -> PAYLOAD -> IDLE; SKIP is used on a length error.
// - IDLE: line idles at 0. data_i=1 is the start bit; go to NODE and clear the bit counter.
// - NODE: shift tag_lg_els_p bits into node shadow, LSB first; then DNR.
// - DNR: capture 1 bit; then LEN.
// - LEN: shift lg_payload_width_lp bits, LSB first. On the last LEN bit:
//   - len==0: emit, go to IDLE.
//   - len>max_payload_width_p: len_err_o=1 next cycle, go to SKIP.
//   - otherwise: go to PAYLOAD.
// - PAYLOAD: bit k is written to shadow[k]; the shadow is cleared on the start bit. After len bits, emit and go to IDLE.
// - SKIP: discard exactly len bits, then IDLE. No v_o is produced, and the output registers are not modified.
// - Emit: the shadow is copied to the output registers and v_o=1 in the cycle after the last sampled bit.
//   - Latency: start-bit sample to v_o = 1+tag_lg_els_p+1+lg_payload_width_lp+len cycles.
// - Back-to-back packets: the FSM is in IDLE during the v_o cycle and samples data_i, so a start bit in that cycle is accepted.
// - Output registers hold their value until the next emit. v_o and len_err_o are never high for two consecutive cycles.
// - pkt_count_o increments on each v_o and saturates at 8'hFF. It only returns to 0 through reset.
// - Reset (any state, including mid-packet):
//   - State goes to IDLE.
//   - All outputs and shadows go to 0 the cycle after reset_i is sampled high.
//   - data_i is ignored while reset_i=1.
//   - The first start bit seen after reset deasserts begins a new frame.
//
// CONFIGURATION
// - BSG_CHIP_TAG_RX_PARITY_EN defined:
//   - The frame carries one extra even-parity bit after the payload (or after LEN when len==0).
//   - Parity covers node, dnr, len and payload bits.
//   - PARITY state is inserted before emit, so latency is +1.
//   - On mismatch: no v_o; parity_err_o (extra 1-bit output port, reset 0) pulses for one cycle; output registers unchanged.
// - BSG_CHIP_TAG_RX_PARITY_EN undefined:
//   - No parity bit, no PARITY state, no parity_err_o port.
//
// TESTING (defaults: tag_lg_els_p=9, max=16)
// - Basic: node=0x02A, dnr=1, len=8, payload=0xA5; start bit sampled at cycle 0.
//   -> v_o only at cycle 24; node_id_o=0x02A, data_not_reset_o=1, len_o=8, payload_o=16'h00A5.
// - Zero length: node=0x1FF, dnr=0, len=0.
//   -> v_o at cycle 16; payload_o=0, len_o=0; pkt_count_o increments by 1.
// - Length error: len=20 followed by 20 arbitrary bits, then node=0x003, len=4, payload=0xF.
//   -> len_err_o pulses once and no v_o for the bad frame; the next frame yields v_o with payload_o=16'h000F.
// - Reset mid-packet: reset_i high for 1 cycle during payload bit 5.
//   -> next cycle all outputs are 0; a subsequent full frame decodes correctly.
// - Back-to-back: second start bit driven in the v_o cycle of the first frame.
//   -> both frames emitted; pkt_count_o advances by 2.
//   - 300 frames -> pkt_count_o=8'hFF (saturated).
// - Parity (with BSG_CHIP_TAG_RX_PARITY_EN): basic frame with flipped parity bit.
//   -> parity_err_o pulses at cycle 25, no v_o; correct parity -> v_o at cycle 25.

Source files
------------

// File: rtl/bsg_chip_tag_packet_rx.sv
// bsg_chip_tag_packet_rx: serial bsg_tag packet receiver (tag_clk domain).
// Frame on data_i, LSB first: start(1) node_id dnr len payload[len].
// Optional build macro BSG_CHIP_TAG_RX_PARITY_EN appends one even-parity bit
// covering node/dnr/len/payload and adds the parity_err_o port.
module bsg_chip_tag_packet_rx #(
    parameter int unsigned tag_lg_els_p        = 9,
    parameter int unsigned max_payload_width_p = 16,
    parameter int unsigned lg_payload_width_lp = $clog2(max_payload_width_p + 1)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           data_i,
    output logic                           v_o,
    output logic [tag_lg_els_p-1:0]        node_id_o,
    output logic                           data_not_reset_o,
    output logic [lg_payload_width_lp-1:0] len_o,
    output logic [max_payload_width_p-1:0] payload_o,
    output logic                           len_err_o,
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
    output logic                           parity_err_o,
`endif
    output logic [7:0]                     pkt_count_o
);

    // Bit counter must cover the node field and the largest encodable len.
    localparam int unsigned len_span_lp = 1 << lg_payload_width_lp;
    localparam int unsigned cnt_max_lp  = (tag_lg_els_p > len_span_lp) ? tag_lg_els_p : len_span_lp;
    localparam int unsigned cnt_w_lp    = $clog2(cnt_max_lp + 1);

    localparam logic [2:0] s_idle    = 3'd0;
    localparam logic [2:0] s_node    = 3'd1;
    localparam logic [2:0] s_dnr     = 3'd2;
    localparam logic [2:0] s_len     = 3'd3;
    localparam logic [2:0] s_payload = 3'd4;
    localparam logic [2:0] s_skip    = 3'd5;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
    localparam logic [2:0] s_parity  = 3'd6;
`endif

    logic [2:0]                     state_r, state_n;
    logic [cnt_w_lp-1:0]            cnt_r, cnt_n, cnt_inc;
    logic [tag_lg_els_p-1:0]        node_r, node_n, node_o_n;
    logic                           dnr_r, dnr_n, dnr_o_n;
    logic [lg_payload_width_lp-1:0] len_r, len_n, len_o_n;
    logic [max_payload_width_p-1:0] pay_r, pay_n, pay_o_n;
    logic                           v_n, len_err_n, emit, done;
    logic [7:0]                     pkt_n;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
    logic                           par_r, par_n, par_err_n;
`endif

    assign cnt_inc = cnt_r + 1'b1;

    // Next-state, shadow capture and output-register update.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        node_n    = node_r;
        dnr_n     = dnr_r;
        len_n     = len_r;
        pay_n     = pay_r;
        v_n       = 1'b0;
        len_err_n = 1'b0;
        emit      = 1'b0;
        done      = 1'b0;
        node_o_n  = node_id_o;
        dnr_o_n   = data_not_reset_o;
        len_o_n   = len_o;
        pay_o_n   = payload_o;
        pkt_n     = pkt_count_o;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
        par_n     = par_r;
        par_err_n = 1'b0;
        if (state_r == s_node || state_r == s_dnr || state_r == s_len || state_r == s_payload)
            par_n = par_r ^ data_i;
`endif
        case (state_r)
            s_idle: begin
                if (data_i) begin
                    state_n = s_node;
                    cnt_n   = '0;
                    node_n  = '0;
                    dnr_n   = 1'b0;
                    len_n   = '0;
                    pay_n   = '0;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
                    par_n   = 1'b0;
`endif
                end
            end
            s_node: begin
                node_n = node_r | (tag_lg_els_p'(data_i) << cnt_r);
                cnt_n  = cnt_inc;
                if (cnt_inc == cnt_w_lp'(tag_lg_els_p)) begin
                    state_n = s_dnr;
                    cnt_n   = '0;
                end
            end
            s_dnr: begin
                dnr_n   = data_i;
                state_n = s_len;
            end
            s_len: begin
                len_n = len_r | (lg_payload_width_lp'(data_i) << cnt_r);
                cnt_n = cnt_inc;
                if (cnt_inc == cnt_w_lp'(lg_payload_width_lp)) begin
                    cnt_n = '0;
                    if (len_n == '0) begin
                        done = 1'b1;
                    end else if (len_n > lg_payload_width_lp'(max_payload_width_p)) begin
                        state_n   = s_skip;
                        len_err_n = 1'b1;
                    end else begin
                        state_n = s_payload;
                    end
                end
            end
            s_payload: begin
                pay_n = pay_r | (max_payload_width_p'(data_i) << cnt_r);
                cnt_n = cnt_inc;
                if (cnt_inc == cnt_w_lp'(len_r)) begin
                    cnt_n = '0;
                    done  = 1'b1;
                end
            end
            s_skip: begin
                cnt_n = cnt_inc;
                if (cnt_inc == cnt_w_lp'(len_r)) begin
                    cnt_n   = '0;
                    state_n = s_idle;
                end
            end
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
            s_parity: begin
                state_n = s_idle;
                if (par_r ^ data_i) par_err_n = 1'b1;
                else                emit      = 1'b1;
            end
`endif
            default: state_n = s_idle;
        endcase

`ifdef BSG_CHIP_TAG_RX_PARITY_EN
        if (done) state_n = s_parity;
`else
        if (done) begin
            state_n = s_idle;
            emit    = 1'b1;
        end
`endif

        if (emit) begin
            v_n      = 1'b1;
            node_o_n = node_n;
            dnr_o_n  = dnr_n;
            len_o_n  = len_n;
            pay_o_n  = pay_n;
            if (pkt_count_o != 8'hFF) pkt_n = pkt_count_o + 8'd1;
        end
    end

    // State, shadow and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r          <= s_idle;
            cnt_r            <= '0;
            node_r           <= '0;
            dnr_r            <= 1'b0;
            len_r            <= '0;
            pay_r            <= '0;
            v_o              <= 1'b0;
            len_err_o        <= 1'b0;
            node_id_o        <= '0;
            data_not_reset_o <= 1'b0;
            len_o            <= '0;
            payload_o        <= '0;
            pkt_count_o      <= '0;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
            par_r            <= 1'b0;
            parity_err_o     <= 1'b0;
`endif
        end else begin
            state_r          <= state_n;
            cnt_r            <= cnt_n;
            node_r           <= node_n;
            dnr_r            <= dnr_n;
            len_r            <= len_n;
            pay_r            <= pay_n;
            v_o              <= v_n;
            len_err_o        <= len_err_n;
            node_id_o        <= node_o_n;
            data_not_reset_o <= dnr_o_n;
            len_o            <= len_o_n;
            payload_o        <= pay_o_n;
            pkt_count_o      <= pkt_n;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
            par_r            <= par_n;
            parity_err_o     <= par_err_n;
`endif
        end
    end

endmodule

// File: tb/tb_bsg_chip_tag_packet_rx.sv
// Bench for bsg_chip_tag_packet_rx: a frame scheduler builds the whole serial
// stream up front and records, per cycle, which pulses and held outputs must
// be visible; the run loop then drives the stream and compares every cycle.
module tb_bsg_chip_tag_packet_rx;

    localparam int node_w = 9;
    localparam int max_w  = 16;
    localparam int len_w  = 5;
    localparam int depth  = 32768;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
    localparam int par_lat = 1;
`else
    localparam int par_lat = 0;
`endif

    logic              clk = 1'b0;
    logic              reset_i;
    logic              data_i;
    logic              v_o;
    logic [node_w-1:0] node_id_o;
    logic              data_not_reset_o;
    logic [len_w-1:0]  len_o;
    logic [max_w-1:0]  payload_o;
    logic              len_err_o;
    logic [7:0]        pkt_count_o;
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
    logic              parity_err_o;
`endif

    bsg_chip_tag_packet_rx dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .data_i           (data_i),
        .v_o              (v_o),
        .node_id_o        (node_id_o),
        .data_not_reset_o (data_not_reset_o),
        .len_o            (len_o),
        .payload_o        (payload_o),
        .len_err_o        (len_err_o),
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
        .parity_err_o     (parity_err_o),
`endif
        .pkt_count_o      (pkt_count_o)
    );

    always #5 clk = ~clk;

    // Stream and expected-event schedule, indexed by cycle.
    bit bits  [depth];
    bit rst   [depth];
    bit ev_v  [depth];
    bit ev_le [depth];
    int ev_node [depth];
    int ev_dnr  [depth];
    int ev_len  [depth];
    int ev_pay  [depth];

    int wp     = 0;
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int p_basic, p_zero, p_lerr, p_good, p_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic put(input bit b, input bit r);
        bits[wp] = b;
        rst[wp]  = r;
        wp++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0);
    endtask

    // Append one complete frame; returns the start-bit cycle.
    task automatic frame(input int node, input int dnr, input int len, input int pay, output int s);
        bit p;
        bit b;
        int e;
        p = 1'b0;
        s = wp;
        put(1'b1, 1'b0);
        for (int i = 0; i < node_w; i++) begin b = bit'((node >> i) & 1); p ^= b; put(b, 1'b0); end
        b = bit'(dnr & 1); p ^= b; put(b, 1'b0);
        for (int i = 0; i < len_w; i++) begin b = bit'((len >> i) & 1); p ^= b; put(b, 1'b0); end
        if (len > max_w) begin
            ev_le[s + 1 + node_w + 1 + len_w] = 1'b1;
            for (int i = 0; i < len; i++) put(bit'($urandom % 2), 1'b0);
        end else begin
            for (int i = 0; i < len; i++) begin b = bit'((pay >> i) & 1); p ^= b; put(b, 1'b0); end
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
            put(p, 1'b0);
`endif
            e = s + 1 + node_w + 1 + len_w + len + par_lat;
            ev_v[e]    = 1'b1;
            ev_node[e] = node;
            ev_dnr[e]  = dnr & 1;
            ev_len[e]  = len;
            ev_pay[e]  = pay;
        end
    endtask

    task automatic rand_frame(output int s);
        int len, pay;
        len = ($urandom % 16 == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
        pay = int'($urandom) & ((1 << len) - 1);
        frame(int'($urandom % 512), int'($urandom % 2), len, pay, s);
    endtask

    initial begin
        int s, cn, cd, cl, cp, cc;
        reset_i = 1'b1;
        data_i  = 1'b0;

        // Build the schedule.
        put(1'b1, 1'b1);
        put(1'b0, 1'b1);
        idle(3);
        frame('h02A, 1, 8, 'hA5, s);   p_basic = s + 24 + par_lat;
        idle(2);
        frame('h1FF, 0, 0, 0, s);      p_zero  = s + 16 + par_lat;
        idle(1);
        frame('h055, 1, 20, 0, s);     p_lerr  = s + 16;
        frame('h003, 1, 4, 'hF, s);    p_good  = s + 20 + par_lat;
        idle(2);
        rand_frame(s);
        rand_frame(s);
        rand_frame(s);
        idle(2);
        // Partial frame, reset lands on payload bit 5.
        put(1'b1, 1'b0);
        for (int i = 0; i < node_w + 1 + len_w; i++) put((i == node_w + 4) ? 1'b1 : 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) put(1'b1, 1'b0);
        p_rst = wp + 1;
        put(1'b1, 1'b1);
        idle(2);
        frame('h12C, 1, 16, 'hBEEF, s);
        for (int i = 0; i < 320; i++) begin
            idle(int'($urandom_range(0, 3)));
            rand_frame(s);
        end
        idle(30);

        // Drive the stream and compare against the held-value model.
        cn = 0; cd = 0; cl = 0; cp = 0; cc = 0;
        for (int k = 0; k + 1 < wp; k++) begin
            @(negedge clk);
            data_i  = bits[k];
            reset_i = rst[k];
            @(posedge clk);
            #1;
            cyc = k + 1;
            if (rst[k]) begin cn = 0; cd = 0; cl = 0; cp = 0; cc = 0; end
            if (ev_v[cyc]) begin
                cn = ev_node[cyc]; cd = ev_dnr[cyc]; cl = ev_len[cyc]; cp = ev_pay[cyc];
                if (cc < 255) cc++;
            end
            chk("v_o", v_o, ev_v[cyc]);
            chk("len_err_o", len_err_o, ev_le[cyc]);
            chk("node_id_o", node_id_o, cn);
            chk("data_not_reset_o", data_not_reset_o, cd);
            chk("len_o", len_o, cl);
            chk("payload_o", payload_o, cp);
            chk("pkt_count_o", pkt_count_o, cc);
`ifdef BSG_CHIP_TAG_RX_PARITY_EN
            chk("parity_err_o", parity_err_o, 0);
`endif
            if (cyc == p_basic) begin
                chk("basic_v", v_o, 1);
                chk("basic_node", node_id_o, 'h02A);
                chk("basic_dnr", data_not_reset_o, 1);
                chk("basic_len", len_o, 8);
                chk("basic_payload", payload_o, 'h00A5);
                chk("basic_count", pkt_count_o, 1);
            end
            if (cyc == p_zero) begin
                chk("zero_v", v_o, 1);
                chk("zero_node", node_id_o, 'h1FF);
                chk("zero_len", len_o, 0);
                chk("zero_payload", payload_o, 0);
                chk("zero_count", pkt_count_o, 2);
            end
            if (cyc == p_lerr) begin
                chk("lenerr_pulse", len_err_o, 1);
                chk("lenerr_no_v", v_o, 0);
            end
            if (cyc == p_good) begin
                chk("after_err_v", v_o, 1);
                chk("after_err_node", node_id_o, 'h003);
                chk("after_err_payload", payload_o, 'h000F);
                chk("after_err_count", pkt_count_o, 3);
            end
            if (cyc == p_rst) begin
                chk("rst_payload", payload_o, 0);
                chk("rst_node", node_id_o, 0);
                chk("rst_len", len_o, 0);
                chk("rst_count", pkt_count_o, 0);
                chk("rst_v", v_o, 0);
            end
        end
        chk("saturated_count", pkt_count_o, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
